// File: rtl/fp_div_norm_round_pack_if.sv
// Handshake and payload bundle for the FP divider post-divide stage.
interface fp_div_norm_round_pack_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MANT_W:0]         quot;
    logic                    sign_a;
    logic                    sign_b;
    logic [EXP_W-1:0]        exp_a;
    logic [EXP_W-1:0]        exp_b;
    logic                    frac_a_zero;
    logic                    frac_b_zero;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W-1:0] result;
    logic [3:0]              flags;

    modport master (
        output in_valid, quot, sign_a, sign_b, exp_a, exp_b, frac_a_zero, frac_b_zero,
        output out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, quot, sign_a, sign_b, exp_a, exp_b, frac_a_zero, frac_b_zero,
        input  out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_div_norm_round_pack.sv
// Post-divide stage: normalise, round, exponent, special cases and binary32 packing.
// Two registered stages that shift together whenever the output is free or being taken.
module fp_div_norm_round_pack #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24,
    parameter int BIAS   = 127
) (
    input logic                     clk,
    input logic                     rst_n,
    fp_div_norm_round_pack_if.slave bus
);
    localparam int E_W = EXP_W + 2;
    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [E_W-1:0]   E_SAT   = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0]   E_BIAS  = E_W'(BIAS);
    localparam logic [MANT_W-2:0]       QNAN_FR = {1'b1, {(MANT_W-2){1'b0}}};

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic fz);
        if (e == '0)      return CLS_ZERO;
        if (e == EXP_MAX) return fz ? CLS_INF : CLS_NAN;
        return CLS_NUM;
    endfunction

    logic adv;
    assign adv         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1 state
    logic                   v1, s1, g1;
    logic signed [E_W-1:0]  e1;
    logic [MANT_W-1:0]      m1;
    cls_t                   cls_a1, cls_b1;

    logic signed [E_W-1:0]  e_raw;
    assign e_raw = $signed({2'b00, bus.exp_a}) - $signed({2'b00, bus.exp_b}) + E_BIAS;

    // Stage 2 combinational datapath
    logic [MANT_W:0]        m_rnd;
    logic signed [E_W-1:0]  e_rnd;
    logic [MANT_W-2:0]      frac;
    logic [EXP_W+MANT_W-1:0] res_n;
    logic [3:0]             flg_n;

    assign m_rnd = {1'b0, m1} + (MANT_W+1)'(g1);
    // A carry out of rounding means m' is exactly 1.0 at the next exponent, so the fraction is 0.
    assign e_rnd = e1 + $signed({{(E_W-1){1'b0}}, m_rnd[MANT_W]});
    assign frac  = m_rnd[MANT_W] ? '0 : m_rnd[MANT_W-2:0];

    always_comb begin
        res_n = {s1, e_rnd[EXP_W-1:0], frac};
        flg_n = '0;
        if (cls_a1 == CLS_NAN || cls_b1 == CLS_NAN ||
            (cls_a1 == CLS_ZERO && cls_b1 == CLS_ZERO) ||
            (cls_a1 == CLS_INF  && cls_b1 == CLS_INF)) begin
            res_n = {1'b0, EXP_MAX, QNAN_FR};
            flg_n = 4'b1000;
        end else if (cls_a1 == CLS_INF) begin
            res_n = {s1, EXP_MAX, {(MANT_W-1){1'b0}}};
        end else if (cls_b1 == CLS_ZERO) begin
            res_n = {s1, EXP_MAX, {(MANT_W-1){1'b0}}};
            flg_n = 4'b0100;
        end else if (cls_a1 == CLS_ZERO || cls_b1 == CLS_INF) begin
            res_n = {s1, {(EXP_W+MANT_W-1){1'b0}}};
        end else if (!e_rnd[E_W-1] && e_rnd >= E_SAT) begin
            res_n = {s1, EXP_MAX, {(MANT_W-1){1'b0}}};
            flg_n = 4'b0010;
        end else if (e_rnd[E_W-1] || e_rnd == '0) begin
            res_n = {s1, {(EXP_W+MANT_W-1){1'b0}}};
            flg_n = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            s1            <= 1'b0;
            g1            <= 1'b0;
            e1            <= '0;
            m1            <= '0;
            cls_a1        <= CLS_NUM;
            cls_b1        <= CLS_NUM;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
        end else if (adv) begin
            v1     <= bus.in_valid;
            s1     <= bus.sign_a ^ bus.sign_b;
            cls_a1 <= classify(bus.exp_a, bus.frac_a_zero);
            cls_b1 <= classify(bus.exp_b, bus.frac_b_zero);
            if (bus.quot[MANT_W]) begin
                m1 <= bus.quot[MANT_W:1];
                g1 <= bus.quot[0];
                e1 <= e_raw;
            end else begin
                m1 <= bus.quot[MANT_W-1:0];
                g1 <= 1'b0;
                e1 <= e_raw - E_W'(1);
            end
            bus.out_valid <= v1;
            bus.result    <= v1 ? res_n : '0;
            bus.flags     <= v1 ? flg_n : '0;
        end
    end
endmodule

// File: tb/tb_fp_div_norm_round_pack.sv
// Self-checking bench for fp_div_norm_round_pack: directed vectors, specials,
// randomized streaming against an arithmetic reference model, stalls and reset.
module tb_fp_div_norm_round_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fp_div_norm_round_pack_if bus ();

    fp_div_norm_round_pack #(.EXP_W(8), .MANT_W(24), .BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [24:0] quot;
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        fza;
        logic        fzb;
    } beat_t;

    task automatic drive(input beat_t b, input logic v);
        bus.quot        = b.quot;
        bus.sign_a      = b.sa;
        bus.sign_b      = b.sb;
        bus.exp_a       = b.ea;
        bus.exp_b       = b.eb;
        bus.frac_a_zero = b.fza;
        bus.frac_b_zero = b.fzb;
        bus.in_valid    = v;
    endtask

    // Reference: value-level divide post-processing, returns {flags, result}.
    function automatic logic [35:0] ref_model(input beat_t b);
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, s;
        int e;
        longint unsigned q, mant;
        nan_a  = (b.ea == 8'd255) && !b.fza;
        nan_b  = (b.eb == 8'd255) && !b.fzb;
        inf_a  = (b.ea == 8'd255) && b.fza;
        inf_b  = (b.eb == 8'd255) && b.fzb;
        zero_a = (b.ea == 8'd0);
        zero_b = (b.eb == 8'd0);
        s      = b.sa ^ b.sb;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            return {4'b1000, 32'h7FC00000};
        if (inf_a)  return {4'b0000, s, 8'hFF, 23'd0};
        if (zero_b) return {4'b0100, s, 8'hFF, 23'd0};
        if (zero_a || inf_b) return {4'b0000, s, 31'd0};
        e = int'(b.ea) - int'(b.eb) + 127;
        q = longint'(b.quot);
        if (q >= 64'd16777216) mant = (q + 1) / 2;
        else begin
            mant = q;
            e    = e - 1;
        end
        if (mant >= 64'd16777216) begin
            mant = mant / 2;
            e    = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0001, s, 31'd0};
        return {4'b0000, s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [7:0] pick_exp();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(1, 254));
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        logic [23:0] ma, mb;
        longint unsigned num;
        ma = {1'b1, 23'($urandom)};
        mb = {1'b1, 23'($urandom)};
        if ($urandom_range(0, 7) == 0) ma[22:0] = '0;
        if ($urandom_range(0, 7) == 0) mb[22:0] = '0;
        num   = (longint'(ma) << 24) / longint'(mb);
        b.quot = 25'(num);
        b.fza = (ma[22:0] == 23'd0);
        b.fzb = (mb[22:0] == 23'd0);
        b.sa  = 1'($urandom);
        b.sb  = 1'($urandom);
        b.ea  = pick_exp();
        b.eb  = pick_exp();
        if (b.ea == 8'd255) b.fza = 1'($urandom);
        if (b.eb == 8'd255) b.fzb = 1'($urandom);
        return b;
    endfunction

    task automatic test_reset();
        beat_t z;
        z = '0;
        drive(z, 1'b0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.flags !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b r=%h f=%b, expected v=0 r=0 f=0",
                     bus.out_valid, bus.result, bus.flags);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        beat_t       vec[12];
        logic [31:0] exp_r[12];
        logic [3:0]  exp_f[12];
        vec[0]  = '{quot:25'h1800000, sa:1'b0, sb:1'b0, ea:8'd129, eb:8'd128, fza:1'b0, fzb:1'b1};
        exp_r[0] = 32'h40400000; exp_f[0] = 4'b0000;
        vec[1]  = '{quot:25'h0AAAAAA, sa:1'b0, sb:1'b0, ea:8'd127, eb:8'd127, fza:1'b1, fzb:1'b0};
        exp_r[1] = 32'h3F2AAAAA; exp_f[1] = 4'b0000;
        vec[2]  = '{quot:25'h1FFFFFF, sa:1'b0, sb:1'b0, ea:8'd127, eb:8'd127, fza:1'b0, fzb:1'b0};
        exp_r[2] = 32'h40000000; exp_f[2] = 4'b0000;
        vec[3]  = '{quot:25'h1000000, sa:1'b0, sb:1'b0, ea:8'd254, eb:8'd1, fza:1'b1, fzb:1'b1};
        exp_r[3] = 32'h7F800000; exp_f[3] = 4'b0010;
        vec[4]  = '{quot:25'h1000000, sa:1'b0, sb:1'b0, ea:8'd1, eb:8'd254, fza:1'b1, fzb:1'b1};
        exp_r[4] = 32'h00000000; exp_f[4] = 4'b0001;
        vec[5]  = '{quot:25'h1000000, sa:1'b0, sb:1'b0, ea:8'd127, eb:8'd0, fza:1'b1, fzb:1'b1};
        exp_r[5] = 32'h7F800000; exp_f[5] = 4'b0100;
        vec[6]  = '{quot:25'h0000000, sa:1'b0, sb:1'b0, ea:8'd0, eb:8'd0, fza:1'b1, fzb:1'b1};
        exp_r[6] = 32'h7FC00000; exp_f[6] = 4'b1000;
        vec[7]  = '{quot:25'h1800000, sa:1'b1, sb:1'b0, ea:8'd128, eb:8'd255, fza:1'b0, fzb:1'b1};
        exp_r[7] = 32'h80000000; exp_f[7] = 4'b0000;
        vec[8]  = '{quot:25'h1800000, sa:1'b1, sb:1'b0, ea:8'd129, eb:8'd128, fza:1'b0, fzb:1'b1};
        exp_r[8] = 32'hC0400000; exp_f[8] = 4'b0000;
        vec[9]  = '{quot:25'h1000000, sa:1'b0, sb:1'b0, ea:8'd255, eb:8'd127, fza:1'b0, fzb:1'b1};
        exp_r[9] = 32'h7FC00000; exp_f[9] = 4'b1000;
        vec[10] = '{quot:25'h1000000, sa:1'b1, sb:1'b0, ea:8'd255, eb:8'd255, fza:1'b1, fzb:1'b1};
        exp_r[10] = 32'h7FC00000; exp_f[10] = 4'b1000;
        vec[11] = '{quot:25'h1000000, sa:1'b0, sb:1'b1, ea:8'd255, eb:8'd0, fza:1'b1, fzb:1'b1};
        exp_r[11] = 32'hFF800000; exp_f[11] = 4'b0000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vec[i], 1'b1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL directed_early[%0d]: out_valid got %b expected 0", i, bus.out_valid);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result !== exp_r[i] || bus.flags !== exp_f[i]) begin
                fails++;
                $display("FAIL directed[%0d]: got v=%b r=%h f=%b expected v=1 r=%h f=%b",
                         i, bus.out_valid, bus.result, bus.flags, exp_r[i], exp_f[i]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.out_valid !== 1'b0 || bus.flags !== 4'd0) begin
                fails++;
                $display("FAIL directed_idle[%0d]: got v=%b f=%b expected v=0 f=0",
                         i, bus.out_valid, bus.flags);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [35:0] q[$];
        logic [35:0] exp_v;
        beat_t       cur;
        logic        iv, accepted, prev_stall;
        logic [31:0] prev_res;
        logic [3:0]  prev_flg;
        iv = 1'b0;
        accepted = 1'b1;
        prev_stall = 1'b0;
        prev_res = '0;
        prev_flg = '0;
        cur = rand_beat();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (accepted || !iv) begin
                cur = rand_beat();
                iv  = ($urandom_range(0, 3) != 0);
            end
            drive(cur, iv);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            tests++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                fails++;
                $display("FAIL stream_in_ready: got %b with out_valid=%b out_ready=%b",
                         bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (prev_stall) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.result !== prev_res || bus.flags !== prev_flg) begin
                    fails++;
                    $display("FAIL stream_hold: got v=%b r=%h f=%b expected v=1 r=%h f=%b",
                             bus.out_valid, bus.result, bus.flags, prev_res, prev_flg);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: got r=%h with no beat outstanding", bus.result);
                end else begin
                    exp_v = q.pop_front();
                    if ({bus.flags, bus.result} !== exp_v) begin
                        fails++;
                        $display("FAIL stream_data: got f=%b r=%h expected f=%b r=%h",
                                 bus.flags, bus.result, exp_v[35:32], exp_v[31:0]);
                    end
                end
            end
            if (bus.out_valid === 1'b0) begin
                tests++;
                if (bus.flags !== 4'd0) begin
                    fails++;
                    $display("FAIL stream_idle_flags: got %b expected 0", bus.flags);
                end
            end
            accepted = iv && (bus.in_ready === 1'b1);
            if (accepted) q.push_back(ref_model(cur));
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_res = bus.result;
            prev_flg = bus.flags;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL drain_extra: got r=%h with no beat outstanding", bus.result);
                end else begin
                    exp_v = q.pop_front();
                    if ({bus.flags, bus.result} !== exp_v) begin
                        fails++;
                        $display("FAIL drain_data: got f=%b r=%h expected f=%b r=%h",
                                 bus.flags, bus.result, exp_v[35:32], exp_v[31:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL stream_lost: got %0d beats outstanding expected 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        beat_t       b[3];
        logic [35:0] got[$];
        logic [31:0] held;
        int          idx, stall_cnt;
        for (int i = 0; i < 3; i++) begin
            b[i] = rand_beat();
            b[i].ea = 8'(120 + i);
            b[i].eb = 8'd127;
        end
        idx = 0;
        stall_cnt = 0;
        held = '0;
        drive(b[0], 1'b1);
        for (int cyc = 0; cyc < 15; cyc++) begin
            bus.out_ready = (stall_cnt >= 3);
            #1;
            if (bus.out_valid === 1'b1 && !bus.out_ready) begin
                stall_cnt++;
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_in_ready: got %b expected 0 during stall", bus.in_ready);
                end
                if (stall_cnt > 1) begin
                    tests++;
                    if (bus.result !== held) begin
                        fails++;
                        $display("FAIL b2b_hold: got %h expected %h", bus.result, held);
                    end
                end
                held = bus.result;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) got.push_back({bus.flags, bus.result});
            if (idx < 3 && bus.in_valid && bus.in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
            if (idx < 3) drive(b[idx], 1'b1);
            else bus.in_valid = 1'b0;
        end
        tests++;
        if (stall_cnt != 3) begin
            fails++;
            $display("FAIL b2b_stall_len: got %0d expected 3", stall_cnt);
        end
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got[i] !== ref_model(b[i])) begin
                    fails++;
                    $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], ref_model(b[i]));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        beat_t b0, b1, z;
        b0 = '{quot:25'h1800000, sa:1'b0, sb:1'b0, ea:8'd129, eb:8'd128, fza:1'b0, fzb:1'b1};
        b1 = '{quot:25'h1FFFFFF, sa:1'b1, sb:1'b0, ea:8'd127, eb:8'd127, fza:1'b0, fzb:1'b0};
        z  = '0;
        bus.out_ready = 1'b0;
        drive(b0, 1'b1);
        @(posedge clk);
        #1;
        drive(b1, 1'b1);
        @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midflight_setup: out_valid got %b expected 1", bus.out_valid);
        end
        drive(z, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.flags !== 4'd0 ||
            bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midflight_reset: got v=%b r=%h f=%b rdy=%b expected 0 0 0 1",
                     bus.out_valid, bus.result, bus.flags, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midflight_stale: got v=%b r=%h expected no result",
                         bus.out_valid, bus.result);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random_stream();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
